// File: rtl/w_writeback_pkg.sv
// Shared types for the writeback stage: register-file mux selects, the MEM/WB
// pipeline bundle and the writeback state encoding.
package regfilemux;
  typedef enum logic [3:0] {
    alu_out  = 4'd0,
    br_en    = 4'd1,
    u_imm    = 4'd2,
    lw       = 4'd3,
    pc_plus4 = 4'd4,
    lb       = 4'd5,
    lbu      = 4'd6,
    lh       = 4'd7,
    lhu      = 4'd8
  } regfilemux_sel_t;
endpackage

package rv32i_types;
  localparam int unsigned XLEN = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WRITE   = 2'd1,
    WAIT_LD = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [XLEN-1:0]              pc;
    logic [REG_W-1:0]             rd;
    regfilemux::regfilemux_sel_t  regfilemux_sel;
    logic [XLEN-1:0]              alu_out;
    logic                         br_en;
    logic [XLEN-1:0]              u_imm;
    logic                         load_regfile;
    logic [1:0]                   addr_lo;
  } MEM_WB_stage_t;

  // Loads must wait for the data-memory response before they can retire.
  function automatic logic is_load(input regfilemux::regfilemux_sel_t sel);
    return sel inside {regfilemux::lw, regfilemux::lb, regfilemux::lbu,
                       regfilemux::lh, regfilemux::lhu};
  endfunction
endpackage

// File: rtl/w_writeback_if.sv
// MEM -> WB handshake: valid/ready plus the instruction bundle.
interface w_writeback_if;
  import rv32i_types::*;

  logic          mem_valid;
  logic          mem_ready;
  MEM_WB_stage_t mem_in;

  modport master (output mem_valid, output mem_in, input mem_ready);
  modport slave  (input mem_valid, input mem_in, output mem_ready);
endinterface

// File: rtl/w_writeback_load_align.sv
// Picks the addressed byte/halfword out of a load word and sign/zero-extends it.
module load_align
  import regfilemux::*;
(
  input  logic [31:0]     rdata,
  input  logic [1:0]      addr_lo,
  input  regfilemux_sel_t sel,
  output logic [31:0]     word
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(rdata >> {addr_lo, 3'b000});
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (sel)
      lb:      word = {{24{byte_v[7]}}, byte_v};
      lbu:     word = {24'd0, byte_v};
      lh:      word = {{16{half_v[15]}}, half_v};
      lhu:     word = {16'd0, half_v};
      default: word = rdata;
    endcase
  end
endmodule

// File: rtl/w_writeback.sv
// Writeback stage: holds one retiring instruction, waits for load data when
// needed, drives the register-file write port and counts retired instructions.
module w_writeback
  import regfilemux::*;
  import rv32i_types::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  w_writeback_if.slave      mem,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  input  logic              flush,
  output logic              rf_load,
  output logic [REG_W-1:0]  rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  instret
);
  wb_state_t       state_q, state_d;
  MEM_WB_stage_t   held_q;
  logic [CNT_W-1:0] instret_q;
  logic            accept, retire;
  logic [XLEN-1:0] rdata_x, load_word, wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Flush dominates: it blocks both retirement and acceptance.
  always_comb begin
    state_d        = state_q;
    mem.mem_ready  = 1'b1;
    accept         = 1'b0;
    retire         = 1'b0;
    case (state_q)
      EMPTY, WRITE: begin
        retire = (state_q == WRITE) && !flush;
        accept = mem.mem_valid && !flush;
        if (accept) state_d = is_load(mem.mem_in.regfilemux_sel) ? WAIT_LD : WRITE;
        else        state_d = EMPTY;
      end
      WAIT_LD: begin
        mem.mem_ready = 1'b0;
        retire        = dmem_resp && !flush;
        if (flush || dmem_resp) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        held_q <= '0;
    else if (accept) held_q <= mem.mem_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  assign rdata_x = XLEN'(dmem_rdata);

  load_align u_load_align (
    .rdata   (rdata_x),
    .addr_lo (held_q.addr_lo),
    .sel     (held_q.regfilemux_sel),
    .word    (load_word)
  );

  always_comb begin
    case (held_q.regfilemux_sel)
      regfilemux::br_en:    wdata = {{(XLEN-1){1'b0}}, held_q.br_en};
      regfilemux::u_imm:    wdata = held_q.u_imm;
      regfilemux::pc_plus4: wdata = held_q.pc + XLEN'(4);
      regfilemux::lw:       wdata = rdata_x;
      regfilemux::lb, regfilemux::lbu,
      regfilemux::lh, regfilemux::lhu: wdata = load_word;
      default:              wdata = held_q.alu_out;
    endcase
  end

  assign rf_load   = retire && held_q.load_regfile && (held_q.rd != '0);
  assign rf_rd     = held_q.rd;
  assign rf_wdata  = DATA_W'(wdata);
  assign fwd_valid = rf_load;
  assign fwd_rd    = rf_rd;
  assign fwd_data  = rf_wdata;
  assign instret   = instret_q;
endmodule
